phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter N_PHASES, default 3, number of machine-cycle phases per instruction cycle; legal range 2..8.
REQ-002 Parameter WAIT_STATES, default 0, extra clocks each phase is held (phase length = WAIT_STATES+1 clocks); legal range 0..15.
REQ-003 Parameter PAUSE_PHASE, default 1, phase index at which a control-unit pause request is honoured; legal range 0..N_PHASES-1.
REQ-004 Parameter CNT_W, default 16, width of the completed-cycle counter.
REQ-005 i_CLOCK  input  1  single system clock; all state changes on its rising edge.
REQ-006 i_RESET_N  input  1  asynchronous, active-low reset.
REQ-007 i_CUCPAUSE  input  1  pause request from the control unit, level.
REQ-008 i_IOSTATE  input  1  toggle token from IO; the sequencer resumes when it equals the internal pause token.
REQ-009 i_STALL  input  1  level hold; freezes the sequencer for every clock it is high.
REQ-010 i_STEP_MODE  input  1  1 = halt after every completed cycle.
REQ-011 i_STEP  input  1  single-clock pulse releasing one cycle in step mode.
REQ-012 o_PHASE  output  N_PHASES  one-hot active phase; all-zero when not running.
REQ-013 o_PHASE_STB  output  1  one-clock pulse on the first clock of each phase.
REQ-014 o_STATE  output  clog2(N_PHASES)  index of the current or next phase.
REQ-015 o_CYCLE_DONE  output  1  one-clock pulse on the last clock of phase N_PHASES-1.
REQ-016 o_PAUSED  output  1  high while waiting for the IO token.
REQ-017 o_HALTED  output  1  high while waiting for i_STEP in step mode.
REQ-018 o_CYCLE_COUNT  output  CNT_W  count of completed cycles.

Function
REQ-019 The controller SHALL use four states: START, RUN, PAUSED, HALT.
REQ-020 START SHALL go to RUN on the first clock after reset release, with o_PHASE[0]=1 and o_PHASE_STB=1 from that clock.
REQ-021 In RUN, a per-phase wait counter SHALL count 0..WAIT_STATES; at WAIT_STATES the phase index SHALL advance by one, wrapping from N_PHASES-1 to 0.
REQ-022 i_STALL=1 SHALL freeze the phase index, wait counter, outputs and cycle counter; o_PHASE_STB and o_CYCLE_DONE SHALL be 0 while stalled.
REQ-023 i_STALL SHALL have priority over pause, halt and step.
REQ-024 If i_CUCPAUSE=1 on the last clock of phase PAUSE_PHASE, the sequencer SHALL toggle its pause token, complete the phase, and enter PAUSED.
REQ-025 In PAUSED, o_PHASE SHALL be 0, o_STATE SHALL hold the next phase index, and o_PAUSED SHALL be 1.
REQ-026 PAUSED SHALL go to RUN on the first clock where i_IOSTATE equals the pause token, resuming at the held index with o_PHASE_STB=1.
REQ-027 On the last clock of phase N_PHASES-1 (not stalled), o_CYCLE_DONE SHALL pulse and o_CYCLE_COUNT SHALL increment, wrapping from 2^CNT_W-1 to 0.
REQ-028 If i_STEP_MODE=1 when a cycle completes, the sequencer SHALL enter HALT with o_PHASE=0, o_STATE=0 and o_HALTED=1.
REQ-029 HALT SHALL go to RUN at phase 0 on the clock after i_STEP=1, or when i_STEP_MODE falls.
REQ-030 If pause and halt fall on the same clock (PAUSE_PHASE=N_PHASES-1), PAUSED SHALL be entered first; after resume, the sequencer SHALL enter HALT before phase 0 when i_STEP_MODE is still 1.
REQ-031 i_STEP outside HALT SHALL be ignored, and SHALL NOT be remembered.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 Asserting i_RESET_N low at any time, including mid-phase or while PAUSED/HALT, SHALL immediately force: state START, phase index 0, wait counter 0, pause token 0, o_PHASE=0, o_PHASE_STB=0, o_STATE=0, o_CYCLE_DONE=0, o_PAUSED=0, o_HALTED=0, o_CYCLE_COUNT=0.

Structure
REQ-034 The state encoding and the parameter legal-range limits SHALL live in a shared package, e.g. cpu_timing_pkg.
REQ-035 The wait-state counter plus phase-index wrap SHALL be one sub-module, phase_counter; the FSM, pause token and cycle counter SHALL stay in the top level.
REQ-036 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-037 Defaults, reset released, 9 clocks -> o_PHASE sequence 001,010,100 repeated 3 times; o_CYCLE_DONE pulses on clocks 3, 6 and 9; o_CYCLE_COUNT=3.
REQ-038 WAIT_STATES=2, N_PHASES=4 -> each o_PHASE bit is high for 3 clocks; o_PHASE_STB pulses every 3rd clock; o_CYCLE_DONE pulses every 12 clocks.
REQ-039 i_CUCPAUSE=1 during phase 1, i_IOSTATE=0 -> o_PAUSED=1 and o_PHASE=0 with o_STATE=2; i_IOSTATE then toggles to 1 -> next clock o_PHASE=100 and o_PHASE_STB=1.
REQ-040 i_STEP_MODE=1 -> o_HALTED=1 after 1 cycle; i_STEP pulse -> exactly one more cycle runs, o_CYCLE_COUNT +1, then HALT again.
REQ-041 i_STALL high for 5 clocks mid-phase 2 -> all outputs frozen; no pulses during the stall.
REQ-042 i_RESET_N asserted while PAUSED -> all outputs reset asynchronously; phase 0 on the first clock after release.
REQ-043 CNT_W=4, run 16 cycles -> o_CYCLE_COUNT wraps to 0.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: controller state encoding and
// the legal ranges of the sequencer parameters.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_e;

    localparam int N_PHASES_MIN    = 2;
    localparam int N_PHASES_MAX    = 8;
    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W_MIN       = 1;

endpackage

// File: rtl/phase_sequencer_phase_counter.sv
// phase_counter: wait-state counter plus phase-index wrap.
//   i_clk/i_rst_n : clock, asynchronous active-low reset
//   i_en          : advance by one clock of phase time
//   o_idx/o_last  : current phase index, current clock is the last of its phase
//   o_idx_d       : phase index after this clock edge
//   o_first_d     : the clock after this edge is the first of its phase
//   o_last_d      : the clock after this edge is the last of its phase
module phase_counter #(
    parameter int N_PHASES    = 3,
    parameter int WAIT_STATES = 0,
    parameter int IDX_W       = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic [IDX_W-1:0] o_idx_d,
    output logic             o_first_d,
    output logic             o_last_d
);

    localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_STATES);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_PHASES - 1);

    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        idx_d  = idx_q;
        wait_d = wait_q;
        if (i_en) begin
            if (wait_q == WAIT_MAX) begin
                wait_d = '0;
                idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q  <= '0;
            wait_q <= '0;
        end else begin
            idx_q  <= idx_d;
            wait_q <= wait_d;
        end
    end

    assign o_idx     = idx_q;
    assign o_last    = (wait_q == WAIT_MAX);
    assign o_idx_d   = idx_d;
    assign o_first_d = (wait_d == '0);
    assign o_last_d  = (wait_d == WAIT_MAX);

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: machine-cycle phase generator with wait states, IO pause
// handshake, single-step halt, stall and a completed-cycle counter.
//   i_CLOCK, i_RESET_N    : clock, asynchronous active-low reset
//   i_CUCPAUSE, i_IOSTATE : pause request / IO resume token
//   i_STALL               : freeze everything while high
//   i_STEP_MODE, i_STEP   : halt after each cycle / release one cycle
//   o_PHASE, o_PHASE_STB  : one-hot phase, first-clock-of-phase strobe
//   o_STATE               : current (or next, when stopped) phase index
//   o_CYCLE_DONE          : last clock of the final phase
//   o_PAUSED, o_HALTED    : waiting for IO token / waiting for step
//   o_CYCLE_COUNT         : completed cycles, wrapping
// All outputs are registered.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int N_PHASES    = 3,
    parameter int WAIT_STATES = 0,
    parameter int PAUSE_PHASE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                        i_CLOCK,
    input  logic                        i_RESET_N,
    input  logic                        i_CUCPAUSE,
    input  logic                        i_IOSTATE,
    input  logic                        i_STALL,
    input  logic                        i_STEP_MODE,
    input  logic                        i_STEP,
    output logic [N_PHASES-1:0]         o_PHASE,
    output logic                        o_PHASE_STB,
    output logic [$clog2(N_PHASES)-1:0] o_STATE,
    output logic                        o_CYCLE_DONE,
    output logic                        o_PAUSED,
    output logic                        o_HALTED,
    output logic [CNT_W-1:0]            o_CYCLE_COUNT
);

    localparam int IDX_W = $clog2(N_PHASES);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_PHASES - 1);
    localparam logic [IDX_W-1:0]    PAUSE_IDX = IDX_W'(PAUSE_PHASE);
    localparam logic [N_PHASES-1:0] PHASE0    = N_PHASES'(1);

    if (N_PHASES < N_PHASES_MIN || N_PHASES > N_PHASES_MAX) begin : g_bad_n_phases
        $error("phase_sequencer: N_PHASES out of range 2..8");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
        $error("phase_sequencer: WAIT_STATES out of range 0..15");
    end
    if (PAUSE_PHASE < 0 || PAUSE_PHASE >= N_PHASES) begin : g_bad_pause_phase
        $error("phase_sequencer: PAUSE_PHASE out of range 0..N_PHASES-1");
    end
    if (CNT_W < CNT_W_MIN) begin : g_bad_cnt_w
        $error("phase_sequencer: CNT_W must be at least 1");
    end

    seq_state_e          fsm_q, fsm_d;
    logic                token_q, token_d;
    logic [N_PHASES-1:0] phase_q, phase_d;
    logic                stb_q, stb_d;
    logic [IDX_W-1:0]    state_q, state_d;
    logic                done_q, done_d;
    logic                paused_q, paused_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic             cnt_en;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, first_d, last_d;
    logic             run_d;

    phase_counter #(
        .N_PHASES   (N_PHASES),
        .WAIT_STATES(WAIT_STATES),
        .IDX_W      (IDX_W)
    ) u_phase_counter (
        .i_clk    (i_CLOCK),
        .i_rst_n  (i_RESET_N),
        .i_en     (cnt_en),
        .o_idx    (idx_q),
        .o_last   (last_q),
        .o_idx_d  (idx_d),
        .o_first_d(first_d),
        .o_last_d (last_d)
    );

    // Leaving a phase always advances the counter, so PAUSED holds the next
    // phase index and HALT sits at index 0 without any explicit load.
    always_comb begin
        fsm_d   = fsm_q;
        token_d = token_q;
        cnt_en  = 1'b0;
        if (!i_STALL) begin
            case (fsm_q)
                ST_START: fsm_d = ST_RUN;
                ST_RUN: begin
                    cnt_en = 1'b1;
                    if (last_q) begin
                        if (idx_q == PAUSE_IDX && i_CUCPAUSE) begin
                            token_d = ~token_q;
                            fsm_d   = ST_PAUSED;
                        end else if (idx_q == LAST_IDX && i_STEP_MODE) begin
                            fsm_d = ST_HALT;
                        end
                    end
                end
                ST_PAUSED: begin
                    // A held index of 0 means the pause was taken at the end
                    // of a completed cycle, so a pending step halt applies.
                    if (i_IOSTATE == token_q) begin
                        fsm_d = (idx_q == '0 && i_STEP_MODE) ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (i_STEP || !i_STEP_MODE) fsm_d = ST_RUN;
                end
                default: fsm_d = ST_START;
            endcase
        end
    end

    // Outputs describe the clock following the edge; under stall fsm/index
    // are unchanged so only the strobes need forcing low.
    always_comb begin
        run_d    = (fsm_d == ST_RUN);
        phase_d  = run_d ? (PHASE0 << idx_d) : '0;
        stb_d    = run_d && first_d && !i_STALL;
        done_d   = run_d && (idx_d == LAST_IDX) && last_d && !i_STALL;
        state_d  = idx_d;
        paused_d = (fsm_d == ST_PAUSED);
        halted_d = (fsm_d == ST_HALT);
        count_d  = count_q + CNT_W'(done_d);
    end

    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            fsm_q    <= ST_START;
            token_q  <= 1'b0;
            phase_q  <= '0;
            stb_q    <= 1'b0;
            state_q  <= '0;
            done_q   <= 1'b0;
            paused_q <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            fsm_q    <= fsm_d;
            token_q  <= token_d;
            phase_q  <= phase_d;
            stb_q    <= stb_d;
            state_q  <= state_d;
            done_q   <= done_d;
            paused_q <= paused_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign o_PHASE       = phase_q;
    assign o_PHASE_STB   = stb_q;
    assign o_STATE       = state_q;
    assign o_CYCLE_DONE  = done_q;
    assign o_PAUSED      = paused_q;
    assign o_HALTED      = halted_q;
    assign o_CYCLE_COUNT = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: default instance plus a 4-phase,
// 2-wait-state, 4-bit-counter instance with pause on the final phase.
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst_n, stall, cuc, io, smode, step;

    always #5 clk = ~clk;

    logic [2:0]  p1_phase;  logic p1_stb; logic [1:0] p1_state; logic p1_done;
    logic        p1_paused; logic p1_halted; logic [15:0] p1_count;
    logic [3:0]  p2_phase;  logic p2_stb; logic [1:0] p2_state; logic p2_done;
    logic        p2_paused; logic p2_halted; logic [3:0] p2_count;

    phase_sequencer dut1 (
        .i_CLOCK(clk), .i_RESET_N(rst_n), .i_CUCPAUSE(cuc), .i_IOSTATE(io),
        .i_STALL(stall), .i_STEP_MODE(smode), .i_STEP(step),
        .o_PHASE(p1_phase), .o_PHASE_STB(p1_stb), .o_STATE(p1_state),
        .o_CYCLE_DONE(p1_done), .o_PAUSED(p1_paused), .o_HALTED(p1_halted),
        .o_CYCLE_COUNT(p1_count)
    );

    phase_sequencer #(
        .N_PHASES(4), .WAIT_STATES(2), .PAUSE_PHASE(3), .CNT_W(4)
    ) dut2 (
        .i_CLOCK(clk), .i_RESET_N(rst_n), .i_CUCPAUSE(cuc), .i_IOSTATE(io),
        .i_STALL(stall), .i_STEP_MODE(smode), .i_STEP(step),
        .o_PHASE(p2_phase), .o_PHASE_STB(p2_stb), .o_STATE(p2_state),
        .o_CYCLE_DONE(p2_done), .o_PAUSED(p2_paused), .o_HALTED(p2_halted),
        .o_CYCLE_COUNT(p2_count)
    );

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: position within the instruction cycle in clocks
    localparam int M_START = 0, M_RUN = 1, M_PAUSED = 2, M_HALT = 3;
    int NP[2]  = '{3, 4};
    int LEN[2] = '{1, 3};
    int PP[2]  = '{1, 3};
    int CW[2]  = '{16, 4};
    int m_mode[2], m_pos[2], m_tok[2], m_cnt[2];
    int e_phase[2], e_stb[2], e_state[2], e_done[2], e_paused[2], e_halted[2];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_START; m_pos[k] = 0; m_tok[k] = 0; m_cnt[k] = 0;
            e_phase[k] = 0; e_stb[k] = 0; e_state[k] = 0; e_done[k] = 0;
            e_paused[k] = 0; e_halted[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int len, tot;
        bit pause_now, cyc_end;
        len = LEN[k];
        tot = NP[k] * LEN[k];
        if (stall) begin
            e_stb[k] = 0;
            e_done[k] = 0;
            return;
        end
        case (m_mode[k])
            M_START: m_mode[k] = M_RUN;
            M_RUN: begin
                pause_now = (m_pos[k] % len == len - 1) && (m_pos[k] / len == PP[k]) && cuc;
                cyc_end   = (m_pos[k] == tot - 1);
                m_pos[k]  = (m_pos[k] + 1) % tot;
                if (pause_now) begin
                    m_tok[k] ^= 1;
                    m_mode[k] = M_PAUSED;
                end else if (cyc_end && smode) begin
                    m_mode[k] = M_HALT;
                end
            end
            M_PAUSED: if (int'(io) == m_tok[k])
                m_mode[k] = (m_pos[k] == 0 && smode) ? M_HALT : M_RUN;
            default: if (step || !smode) m_mode[k] = M_RUN;
        endcase
        if (m_mode[k] == M_RUN) begin
            e_phase[k] = 1 << (m_pos[k] / len);
            e_stb[k]   = (m_pos[k] % len == 0) ? 1 : 0;
            e_done[k]  = (m_pos[k] == tot - 1) ? 1 : 0;
        end else begin
            e_phase[k] = 0; e_stb[k] = 0; e_done[k] = 0;
        end
        if (e_done[k] != 0) m_cnt[k] = (m_cnt[k] + 1) % (1 << CW[k]);
        e_state[k]  = m_pos[k] / len;
        e_paused[k] = (m_mode[k] == M_PAUSED) ? 1 : 0;
        e_halted[k] = (m_mode[k] == M_HALT) ? 1 : 0;
    endtask

    task automatic check_models();
        chk("dut1.phase",  32'(p1_phase),  e_phase[0]);
        chk("dut1.stb",    32'(p1_stb),    e_stb[0]);
        chk("dut1.state",  32'(p1_state),  e_state[0]);
        chk("dut1.done",   32'(p1_done),   e_done[0]);
        chk("dut1.paused", 32'(p1_paused), e_paused[0]);
        chk("dut1.halted", 32'(p1_halted), e_halted[0]);
        chk("dut1.count",  32'(p1_count),  m_cnt[0]);
        chk("dut2.phase",  32'(p2_phase),  e_phase[1]);
        chk("dut2.stb",    32'(p2_stb),    e_stb[1]);
        chk("dut2.state",  32'(p2_state),  e_state[1]);
        chk("dut2.done",   32'(p2_done),   e_done[1]);
        chk("dut2.paused", 32'(p2_paused), e_paused[1]);
        chk("dut2.halted", 32'(p2_halted), e_halted[1]);
        chk("dut2.count",  32'(p2_count),  m_cnt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_models();
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_models();
        @(posedge clk);
        #1;
        check_models();
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit stall, cuc, io, smode, step;
        int phase, stb, done, state, paused, halted, count;
    } vec_t;
    vec_t vec[$];

    initial begin
        rst_n = 1'b0; stall = 1'b0; cuc = 1'b0; io = 1'b0; smode = 1'b0; step = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_models();
        rst_n = 1'b1;

        // inputs: stall cuc io smode step | phase stb done state paused halted count
        vec.push_back('{0,0,0,0,0, 1,1,0,0,0,0,0});
        vec.push_back('{0,0,0,0,0, 2,1,0,1,0,0,0});
        vec.push_back('{0,0,0,0,0, 4,1,1,2,0,0,1});
        vec.push_back('{0,0,0,0,0, 1,1,0,0,0,0,1});
        vec.push_back('{0,0,0,0,0, 2,1,0,1,0,0,1});
        vec.push_back('{0,0,0,0,0, 4,1,1,2,0,0,2});
        vec.push_back('{0,0,0,0,0, 1,1,0,0,0,0,2});
        vec.push_back('{0,0,0,0,0, 2,1,0,1,0,0,2});
        vec.push_back('{0,0,0,0,0, 4,1,1,2,0,0,3});
        vec.push_back('{0,0,0,0,0, 1,1,0,0,0,0,3});
        vec.push_back('{0,0,0,0,0, 2,1,0,1,0,0,3});
        vec.push_back('{0,1,0,0,0, 0,0,0,2,1,0,3});   // pause at end of phase 1
        vec.push_back('{0,0,0,0,0, 0,0,0,2,1,0,3});
        vec.push_back('{0,0,1,0,0, 4,1,1,2,0,0,4});   // IO token matches: resume
        vec.push_back('{0,0,1,0,0, 1,1,0,0,0,0,4});
        vec.push_back('{0,0,1,1,0, 2,1,0,1,0,0,4});
        vec.push_back('{0,0,1,1,0, 4,1,1,2,0,0,5});
        vec.push_back('{0,0,1,1,0, 0,0,0,0,0,1,5});   // halted
        vec.push_back('{0,0,1,1,0, 0,0,0,0,0,1,5});
        vec.push_back('{0,0,1,1,1, 1,1,0,0,0,0,5});   // step releases one cycle
        vec.push_back('{0,0,1,1,0, 2,1,0,1,0,0,5});
        vec.push_back('{0,0,1,1,0, 4,1,1,2,0,0,6});
        vec.push_back('{0,0,1,1,0, 0,0,0,0,0,1,6});
        vec.push_back('{0,0,1,0,0, 1,1,0,0,0,0,6});   // step mode dropped
        vec.push_back('{0,0,1,0,1, 2,1,0,1,0,0,6});   // step while running ignored
        vec.push_back('{0,0,1,0,0, 4,1,1,2,0,0,7});
        for (int i = 0; i < 5; i++)
            vec.push_back('{1,0,1,0,0, 4,0,0,2,0,0,7}); // stall in phase 2
        vec.push_back('{0,0,1,0,0, 1,1,0,0,0,0,7});
        vec.push_back('{0,0,1,1,0, 2,1,0,1,0,0,7});
        vec.push_back('{0,0,1,1,0, 4,1,1,2,0,0,8});
        vec.push_back('{0,0,1,1,0, 0,0,0,0,0,1,8});
        vec.push_back('{1,0,1,1,1, 0,0,0,0,0,1,8});   // stall beats step
        vec.push_back('{0,0,1,1,0, 0,0,0,0,0,1,8});   // step not remembered
        vec.push_back('{0,0,1,0,0, 1,1,0,0,0,0,8});

        foreach (vec[i]) begin
            stall = vec[i].stall; cuc = vec[i].cuc; io = vec[i].io;
            smode = vec[i].smode; step = vec[i].step;
            tick();
            chk($sformatf("vec%0d.phase", i),  32'(p1_phase),  vec[i].phase);
            chk($sformatf("vec%0d.stb", i),    32'(p1_stb),    vec[i].stb);
            chk($sformatf("vec%0d.done", i),   32'(p1_done),   vec[i].done);
            chk($sformatf("vec%0d.state", i),  32'(p1_state),  vec[i].state);
            chk($sformatf("vec%0d.paused", i), 32'(p1_paused), vec[i].paused);
            chk($sformatf("vec%0d.halted", i), 32'(p1_halted), vec[i].halted);
            chk($sformatf("vec%0d.count", i),  32'(p1_count),  vec[i].count);
        end

        // Reset while paused
        stall = 0; cuc = 0; io = 0; smode = 0; step = 0;
        do_reset();
        tick();
        tick();
        cuc = 1;
        tick();
        cuc = 0;
        tick();
        chk("rstpause.paused_before", 32'(p1_paused), 1);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rstpause.paused", 32'(p1_paused), 0);
        chk("rstpause.phase",  32'(p1_phase),  0);
        chk("rstpause.state",  32'(p1_state),  0);
        chk("rstpause.count",  32'(p1_count),  0);
        #2 rst_n = 1'b1;
        tick();
        chk("rstpause.first_phase", 32'(p1_phase), 1);
        chk("rstpause.first_stb",   32'(p1_stb),   1);

        // Wait states and 4-bit counter wrap on the second instance
        do_reset();
        for (int k = 1; k <= 192; k++) begin
            tick();
            chk("ws.phase", 32'(p2_phase), 1 << (((k - 1) / 3) % 4));
            chk("ws.stb",   32'(p2_stb),   ((k - 1) % 3 == 0) ? 1 : 0);
            chk("ws.done",  32'(p2_done),  (k % 12 == 0) ? 1 : 0);
            if (k == 180) chk("ws.count15", 32'(p2_count), 15);
        end
        chk("ws.count_wrap", 32'(p2_count), 0);
        chk("ws.dut1_count", 32'(p1_count), 64);

        // Pause and halt on the same clock (second instance pauses on its final phase)
        cuc = 1; smode = 1; io = 0;
        do_reset();
        repeat (13) tick();
        chk("ph.paused", 32'(p2_paused), 1);
        chk("ph.state",  32'(p2_state),  0);
        chk("ph.count",  32'(p2_count),  1);
        cuc = 0; io = 1;
        tick();
        chk("ph.halted", 32'(p2_halted), 1);
        chk("ph.phase",  32'(p2_phase),  0);
        step = 1;
        tick();
        step = 0;
        chk("ph.run_phase", 32'(p2_phase), 1);
        chk("ph.run_stb",   32'(p2_stb),   1);

        // Randomized stimulus against the model
        smode = 0;
        for (int n = 0; n < 1500; n++) begin
            stall = ($urandom % 8) == 0;
            cuc   = ($urandom % 5) == 0;
            if (($urandom % 4) == 0) io = ~io;
            if (($urandom % 16) == 0) smode = ~smode;
            step  = ($urandom % 6) == 0;
            if (($urandom % 400) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
